capture_ctrl_mc: RTL and testbench
==================================

# capture_ctrl_mc

Parametrised multi-channel capture controller for the oscilloscope front end. Generates shared RAM write strobes and addresses for NUM_CH per-channel trace RAMs. Applies a decimation ratio, fills a configurable pre-trigger window, and detects an edge trigger on any selectable channel comparator. Adds auto-trigger and single-shot modes, and signals capture completion to the host-command side.

## Interface

Parameters:
- NUM_CH, 3: number of analog channels / trigger comparator inputs (2..8)
- ADDR_W, 9: trace RAM address width; DEPTH = 2**ADDR_W
- DEC_W, 4: decimator width
- AUTO_TO, 4096: sample writes spent in ARMED before auto mode self-triggers

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- trig  in  NUM_CH  asynchronous comparator outputs, one per channel
- trig_src  in  $clog2(NUM_CH)  trigger channel select; values >= NUM_CH select channel 0
- trig_edge  in  1  1 = rising edge, 0 = falling edge
- trig_mode  in  2  00 stop, 01 normal, 10 auto, 11 single
- trig_pos  in  ADDR_W  number of post-trigger samples, including the trigger sample
- decimator  in  DEC_W  write one sample every decimator+1 clocks
- arm  in  1  single-mode re-arm pulse
- clr_cap_done  in  1  host has read the trace; release DONE
- en, we  out  1  RAM enable/write, common to all channels
- addr  out  ADDR_W  RAM write address
- trace_end  out  ADDR_W  address of last written sample; valid while cap_done
- armed, triggered, cap_done  out  1  status

## Operation

- States: IDLE, PRE, ARMED, POST, DONE. Reset: IDLE, all outputs 0, all counters 0.
- IDLE -> PRE when trig_mode is 01 or 10, or trig_mode is 11 and arm=1. Latch trig_src, trig_edge, trig_pos and decimator. Clear the sample counter. addr is not reset; capture continues from the current addr.
- Latched trig_pos 0 is treated as 1; trig_pos = DEPTH-1 is the maximum. PRE_LEN = DEPTH - trig_pos_latched.
- The sample strobe fires when the decimation counter equals the latched decimator; the counter then reloads 0. In PRE, ARMED and POST, each strobe drives en=we=1 for one clock with the current addr. addr increments on the following edge and wraps DEPTH-1 -> 0.
- PRE -> ARMED after PRE_LEN writes. armed = 1 in ARMED only.
- Trigger path: trig[src] passes through a 2-flop synchroniser plus one edge-history flop. A qualifying edge is accepted only while in ARMED; edges during PRE are discarded.
- ARMED -> POST on an accepted edge, or in auto mode after AUTO_TO writes while ARMED. triggered = 1 from POST entry until leaving DONE.
- POST: after trig_pos_latched writes, the state moves to DONE. trace_end = the address of the final write, and cap_done = 1.
- DONE: no writes. On clr_cap_done: normal/auto -> PRE (re-latch configuration); single -> IDLE; stop -> IDLE. clr_cap_done outside DONE is ignored.
- trig_mode = 00 in any state: next clock goes to IDLE. en/we are 0 from that clock on, armed and triggered are cleared, and cap_done is cleared.
- Configuration inputs are ignored except at latch points.

## Timing

- trig change to accepted edge: 3 clocks. triggered rises on the clock after acceptance.
- Strobe period = decimator+1 clocks. decimator = 0 means a write every clock.
- armed rises on the clock after the PRE_LEN-th write.
- cap_done rises on the clock after the last POST write. trace_end updates on the same edge.
- DONE -> PRE on the clock after clr_cap_done. The first new write occurs decimator+1 clocks later.
- Edge arriving on the same clock armed rises: not accepted.
- rst mid-capture: immediate return to IDLE, addr = 0, outputs 0.

## Test plan

- NUM_CH=3, ADDR_W=9, decimator=2, trig_pos=0x0A1, mode 01, rising, src 0. armed rises after 351 writes, i.e. 1053 strobe clocks. Raise trig[0]: triggered=1 within 4 clocks. 161 further writes, then cap_done=1 with trace_end = address of the 512th write.
- Pulse clr_cap_done with trig_pos changed to 0x013. cap_done=0 and triggered=0 the next clock, PRE_LEN=493, armed re-rises after 493 writes, trig still high gives no trigger until a fresh rising edge.
- Falling edge, src 2, trig[0]/trig[1] toggling, trig[2] static. Must never trigger. Then drop trig[2]: triggered=1 within 4 clocks.
- Auto mode, AUTO_TO=16, no trig activity: triggered=1 on the clock after the 16th ARMED write. cap_done follows after trig_pos writes.
- Single mode, clr_cap_done after DONE: returns IDLE, no writes until arm pulse. trig_pos=0 yields exactly one post write.
- trig_mode -> 00 mid-POST: next clock en=we=0 and state IDLE. rst asserted mid-PRE: addr=0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/capture_ctrl_mc_if.sv
// ---------------------------------------------------------------------------
// capture_ctrl_mc_if
//   Bundle of host configuration, trigger comparator inputs and trace-RAM
//   write/status outputs of the capture controller.
//
//   master : host / front-end side (drives configuration and trig, reads status)
//   slave  : capture controller side
//
//   Signals
//     trig[NUM_CH]    asynchronous comparator outputs
//     trig_src        trigger channel select (>= NUM_CH selects channel 0)
//     trig_edge       1 = rising, 0 = falling
//     trig_mode       00 stop, 01 normal, 10 auto, 11 single
//     trig_pos        post-trigger sample count (including the trigger sample)
//     decimator       one sample every decimator+1 clocks
//     arm             single-mode re-arm pulse
//     clr_cap_done    host has read the trace, release DONE
//     en, we          shared RAM enable / write strobe
//     addr            RAM write address
//     trace_end       address of the last written sample (valid with cap_done)
//     armed, triggered, cap_done  status
//
//   Write strobe semantics: en and we are asserted together for exactly one
//   clock per sample; the RAM must take addr on that same rising edge. There
//   is no back-pressure: the RAM is always ready.
// ---------------------------------------------------------------------------
interface capture_ctrl_mc_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 9,
  parameter int DEC_W  = 4
);
  localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] trig;
  logic [SRC_W-1:0]  trig_src;
  logic              trig_edge;
  logic [1:0]        trig_mode;
  logic [ADDR_W-1:0] trig_pos;
  logic [DEC_W-1:0]  decimator;
  logic              arm;
  logic              clr_cap_done;
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] trace_end;
  logic              armed;
  logic              triggered;
  logic              cap_done;

  modport master (
    output trig, trig_src, trig_edge, trig_mode, trig_pos, decimator, arm,
           clr_cap_done,
    input  en, we, addr, trace_end, armed, triggered, cap_done
  );

  modport slave (
    input  trig, trig_src, trig_edge, trig_mode, trig_pos, decimator, arm,
           clr_cap_done,
    output en, we, addr, trace_end, armed, triggered, cap_done
  );
endinterface

// File: rtl/capture_ctrl_mc.sv
// ---------------------------------------------------------------------------
// capture_ctrl_mc
//   Multi-channel capture controller for the oscilloscope front end. Produces
//   shared write strobes and a wrapping address for NUM_CH trace RAMs, applies
//   decimation, fills a pre-trigger window, waits for an edge on the selected
//   comparator (or an auto-mode timeout), fills the post-trigger window and
//   then holds DONE until the host releases it.
//
//   Ports
//     clk      system clock, rising edge
//     rst      asynchronous active-high reset
//     cap      capture_ctrl_mc_if.slave (configuration, trig, RAM strobes,
//              status)
//     state_o  current FSM state (0 IDLE, 1 PRE, 2 ARMED, 3 POST, 4 DONE)
// ---------------------------------------------------------------------------
module capture_ctrl_mc #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 9,
  parameter int DEC_W   = 4,
  parameter int AUTO_TO = 4096
) (
  input  logic             clk,
  input  logic             rst,
  capture_ctrl_mc_if.slave cap,
  output logic [2:0]       state_o
);

  localparam int SRC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AUTO_W = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
  // One sample counter serves PRE, ARMED (auto timeout) and POST.
  localparam int CW     = (ADDR_W > AUTO_W) ? ADDR_W : AUTO_W;
  localparam logic [CW-1:0] AUTO_LAST = CW'(AUTO_TO - 1);

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_NORM   = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_SINGLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [CW-1:0]     smp_cnt_q, smp_cnt_d;
  logic [ADDR_W-1:0] trace_end_q, trace_end_d;
  logic [DEC_W-1:0]  lat_dec_q, lat_dec_d;
  logic [SRC_W-1:0]  lat_src_q, lat_src_d;
  logic              lat_edge_q, lat_edge_d;
  logic              lat_auto_q, lat_auto_d;
  logic [ADDR_W-1:0] lat_post_q, lat_post_d;   // post length, 0 already mapped to 1
  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic              hist_q;

  logic              active;
  logic              strobe;
  logic              sel_trig;
  logic              edge_hit;
  logic              auto_hit;
  logic              do_latch;
  logic [ADDR_W-1:0] pre_last;
  logic [ADDR_W-1:0] post_last;

  // PRE_LEN - 1 = DEPTH - post - 1, which is simply the bitwise inverse.
  assign pre_last  = ~lat_post_q;
  assign post_last = lat_post_q - 1'b1;

  assign active   = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign strobe   = active && (dec_cnt_q == lat_dec_q);
  assign sel_trig = sync2_q[lat_src_q];

  // Edges are only honoured in ARMED; the PRE->ARMED edge itself is still
  // evaluated with state_q == PRE, so a coincident edge is dropped.
  assign edge_hit = (state_q == S_ARMED) &&
                    (lat_edge_q ? (sel_trig && !hist_q) : (!sel_trig && hist_q));
  assign auto_hit = (state_q == S_ARMED) && lat_auto_q && strobe &&
                    (smp_cnt_q == AUTO_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dec_cnt_d   = dec_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    trace_end_d = trace_end_q;
    lat_dec_d   = lat_dec_q;
    lat_src_d   = lat_src_q;
    lat_edge_d  = lat_edge_q;
    lat_auto_d  = lat_auto_q;
    lat_post_d  = lat_post_q;
    do_latch    = 1'b0;

    if (strobe) begin
      addr_d    = addr_q + 1'b1;
      dec_cnt_d = '0;
    end else if (active) begin
      dec_cnt_d = dec_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if ((cap.trig_mode == MODE_NORM) || (cap.trig_mode == MODE_AUTO) ||
            ((cap.trig_mode == MODE_SINGLE) && cap.arm)) begin
          state_d  = S_PRE;
          do_latch = 1'b1;
        end
      end
      S_PRE: begin
        if (strobe) begin
          if (smp_cnt_q == CW'(pre_last)) begin
            state_d   = S_ARMED;
            smp_cnt_d = '0;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (edge_hit || auto_hit) begin
          state_d   = S_POST;
          smp_cnt_d = '0;
        end else if (strobe) begin
          smp_cnt_d = smp_cnt_q + 1'b1;
        end
      end
      S_POST: begin
        if (strobe) begin
          if (smp_cnt_q == CW'(post_last)) begin
            state_d     = S_DONE;
            trace_end_d = addr_q;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (cap.clr_cap_done) begin
          if ((cap.trig_mode == MODE_NORM) || (cap.trig_mode == MODE_AUTO)) begin
            state_d  = S_PRE;
            do_latch = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_latch) begin
      lat_dec_d  = cap.decimator;
      lat_src_d  = (int'(cap.trig_src) >= NUM_CH) ? '0 : cap.trig_src;
      lat_edge_d = cap.trig_edge;
      lat_auto_d = (cap.trig_mode == MODE_AUTO);
      lat_post_d = (cap.trig_pos == '0) ? ADDR_W'(1) : cap.trig_pos;
      dec_cnt_d  = '0;
      smp_cnt_d  = '0;
    end

    // Stop wins over everything, from any state.
    if (cap.trig_mode == MODE_STOP) begin
      state_d   = S_IDLE;
      dec_cnt_d = '0;
      smp_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dec_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      trace_end_q <= '0;
      lat_dec_q   <= '0;
      lat_src_q   <= '0;
      lat_edge_q  <= 1'b0;
      lat_auto_q  <= 1'b0;
      lat_post_q  <= ADDR_W'(1);
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dec_cnt_q   <= dec_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      trace_end_q <= trace_end_d;
      lat_dec_q   <= lat_dec_d;
      lat_src_q   <= lat_src_d;
      lat_edge_q  <= lat_edge_d;
      lat_auto_q  <= lat_auto_d;
      lat_post_q  <= lat_post_d;
      sync1_q     <= cap.trig;
      sync2_q     <= sync1_q;
      hist_q      <= sel_trig;
    end
  end

  assign cap.en        = strobe;
  assign cap.we        = strobe;
  assign cap.addr      = addr_q;
  assign cap.trace_end = trace_end_q;
  assign cap.armed     = (state_q == S_ARMED);
  assign cap.triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign cap.cap_done  = (state_q == S_DONE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_capture_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_capture_ctrl_mc
//   Directed bench for capture_ctrl_mc (NUM_CH=3, ADDR_W=9, AUTO_TO=16).
//   A negedge monitor keeps the expected write address sequence (wrapping,
//   reset to 0) and counts writes overall, while armed and while triggered.
// ---------------------------------------------------------------------------
module tb_capture_ctrl_mc;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 9;
  localparam int DEC_W   = 4;
  localparam int AUTO_TO = 16;

  localparam int W_ARMED = 0;
  localparam int W_TRIG  = 1;
  localparam int W_DONE  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  capture_ctrl_mc_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEC_W(DEC_W)) cif ();

  capture_ctrl_mc #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DEC_W  (DEC_W),
    .AUTO_TO(AUTO_TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cap    (cif),
    .state_o(state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] exp_q[$];
  int wr_tot    = 0;
  int post_tot  = 0;
  int armed_tot = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_addr = '0;
    end else begin
      if (cif.en || cif.we) check("we_eq_en", 32'(cif.we), 32'(cif.en));
      if (cif.en) begin
        check("wr_addr", 32'(cif.addr), 32'(exp_addr));
        exp_q.push_back(exp_addr);
        exp_addr = exp_addr + 1'b1;
        wr_tot++;
        if (cif.triggered) post_tot++;
        if (cif.armed) armed_tot++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input logic [1:0] mode, input logic [1:0] src, input logic edge_r,
                           input logic [ADDR_W-1:0] pos, input logic [DEC_W-1:0] dec);
    cif.trig_mode = mode;
    cif.trig_src  = src;
    cif.trig_edge = edge_r;
    cif.trig_pos  = pos;
    cif.decimator = dec;
  endtask

  task automatic pulse_clr();
    cif.clr_cap_done = 1'b1;
    tick(1);
    cif.clr_cap_done = 1'b0;
  endtask

  task automatic pulse_arm();
    cif.arm = 1'b1;
    tick(1);
    cif.arm = 1'b0;
  endtask

  function automatic logic flag(input int which);
    case (which)
      W_ARMED: return cif.armed;
      W_TRIG:  return cif.triggered;
      W_DONE:  return cif.cap_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, output int clks);
    clks = 0;
    while (!flag(which) && clks < budget) begin
      tick(1);
      clks++;
    end
    if (!flag(which)) check($sformatf("timeout_%0d", which), 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int base;
    int pbase;
    int abase;

    rst = 1'b1;
    cif.trig = '0;
    cif.arm = 1'b0;
    cif.clr_cap_done = 1'b0;
    drive_cfg(2'b00, 2'd0, 1'b1, '0, '0);

    // Reset state
    #2;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_en", 32'(cif.en), 32'd0);
    check("rst_addr", 32'(cif.addr), 32'd0);
    check("rst_status", {29'd0, cif.armed, cif.triggered, cif.cap_done}, 32'd0);
    check("rst_trace_end", 32'(cif.trace_end), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("stop_idle", 32'(state_o), 32'd0);
    check("stop_no_wr", 32'(wr_tot), 32'd0);

    // S1: normal, rising, src 0, decimator 2, trig_pos 0xA1 -> PRE_LEN 351
    drive_cfg(2'b01, 2'd0, 1'b1, 9'h0A1, 4'd2);
    base = wr_tot;
    tick(1);
    check("s1_pre", 32'(state_o), 32'd1);
    wait_for(W_ARMED, 1200, c);
    check("s1_pre_clks", 32'(c), 32'd1053);
    check("s1_pre_wr", 32'(wr_tot - base), 32'd351);
    check("s1_addr", 32'(cif.addr), 32'd351);
    cif.trig = 3'b001;
    wait_for(W_TRIG, 8, c);
    check("s1_trig_lat", 32'(c <= 4), 32'd1);
    check("s1_armed_low", 32'(cif.armed), 32'd0);
    pbase = post_tot;
    wait_for(W_DONE, 600, c);
    check("s1_post_wr", 32'(post_tot - pbase), 32'd161);
    check("s1_trace_end", 32'(cif.trace_end), 32'(exp_q[exp_q.size()-1]));
    base = wr_tot;
    tick(6);
    check("s1_done_no_wr", 32'(wr_tot - base), 32'd0);
    check("s1_done_hold", 32'(state_o), 32'd4);

    // S2: release with trig_pos 0x013 -> PRE_LEN 493; trig still high
    cif.trig_pos = 9'h013;
    pulse_clr();
    check("s2_clr_done", {30'd0, cif.cap_done, cif.triggered}, 32'd0);
    check("s2_pre", 32'(state_o), 32'd1);
    base = wr_tot;
    wait_for(W_ARMED, 1600, c);
    check("s2_pre_clks", 32'(c), 32'd1479);
    check("s2_pre_wr", 32'(wr_tot - base), 32'd493);
    tick(30);
    check("s2_high_no_trig", 32'(cif.triggered), 32'd0);
    cif.trig = 3'b000;
    tick(10);
    check("s2_fall_no_trig", 32'(cif.triggered), 32'd0);
    cif.trig = 3'b001;
    wait_for(W_TRIG, 8, c);
    check("s2_trig_lat", 32'(c <= 4), 32'd1);
    pbase = post_tot;
    wait_for(W_DONE, 100, c);
    check("s2_post_wr", 32'(post_tot - pbase), 32'd19);
    check("s2_trace_end", 32'(cif.trace_end), 32'(exp_q[exp_q.size()-1]));

    // S3: falling edge on src 2, other channels toggling; PRE_LEN 256, dec 0
    cif.trig = 3'b100;
    drive_cfg(2'b01, 2'd2, 1'b0, 9'h100, 4'd0);
    pulse_clr();
    base = wr_tot;
    wait_for(W_ARMED, 300, c);
    check("s3_pre_clks", 32'(c), 32'd256);
    check("s3_pre_wr", 32'(wr_tot - base), 32'd256);
    for (int i = 0; i < 40; i++) begin
      cif.trig = {1'b1, 2'(i)};
      tick(1);
    end
    tick(4);
    check("s3_no_trig", 32'(cif.triggered), 32'd0);
    check("s3_still_armed", 32'(cif.armed), 32'd1);
    cif.trig = 3'b000;
    wait_for(W_TRIG, 8, c);
    check("s3_trig_lat", 32'(c <= 4), 32'd1);
    pbase = post_tot;
    wait_for(W_DONE, 300, c);
    check("s3_post_wr", 32'(post_tot - pbase), 32'd256);
    check("s3_trace_end", 32'(cif.trace_end), 32'(exp_q[exp_q.size()-1]));

    // S4: auto mode, no trig activity; src 3 maps to channel 0; dec 1, pos 4
    drive_cfg(2'b10, 2'd3, 1'b1, 9'h004, 4'd1);
    pulse_clr();
    base = wr_tot;
    wait_for(W_ARMED, 1100, c);
    check("s4_pre_clks", 32'(c), 32'd1016);
    check("s4_pre_wr", 32'(wr_tot - base), 32'd508);
    abase = armed_tot;
    wait_for(W_TRIG, 60, c);
    check("s4_auto_clks", 32'(c), 32'd32);
    check("s4_armed_wr", 32'(armed_tot - abase), 32'd16);
    pbase = post_tot;
    wait_for(W_DONE, 30, c);
    check("s4_post_wr", 32'(post_tot - pbase), 32'd4);
    check("s4_trace_end", 32'(cif.trace_end), 32'(exp_q[exp_q.size()-1]));

    // S5: single mode; release returns to IDLE, arm starts capture; pos 0 -> 1 write
    cif.trig_mode = 2'b11;
    pulse_clr();
    check("s5_idle", 32'(state_o), 32'd0);
    check("s5_clr_done", {30'd0, cif.cap_done, cif.triggered}, 32'd0);
    drive_cfg(2'b11, 2'd1, 1'b1, 9'h000, 4'd0);
    base = wr_tot;
    tick(20);
    check("s5_idle_no_wr", 32'(wr_tot - base), 32'd0);
    check("s5_wait_arm", 32'(state_o), 32'd0);
    pulse_arm();
    check("s5_pre", 32'(state_o), 32'd1);
    wait_for(W_ARMED, 600, c);
    check("s5_pre_clks", 32'(c), 32'd511);
    check("s5_pre_wr", 32'(wr_tot - base), 32'd511);
    cif.trig = 3'b010;
    wait_for(W_TRIG, 8, c);
    check("s5_trig_lat", 32'(c <= 4), 32'd1);
    pbase = post_tot;
    wait_for(W_DONE, 20, c);
    check("s5_post_wr", 32'(post_tot - pbase), 32'd1);
    check("s5_trace_end", 32'(cif.trace_end), 32'(exp_q[exp_q.size()-1]));
    pulse_clr();
    check("s5_back_idle", 32'(state_o), 32'd0);

    // S6: stop mid-POST; PRE_LEN 16
    cif.trig = 3'b000;
    cif.trig_pos = 9'h1F0;
    pulse_arm();
    wait_for(W_ARMED, 40, c);
    check("s6_pre_clks", 32'(c), 32'd16);
    cif.trig = 3'b010;
    wait_for(W_TRIG, 8, c);
    tick(5);
    check("s6_in_post", 32'(state_o), 32'd3);
    cif.trig_mode = 2'b00;
    tick(1);
    check("s6_stop_state", 32'(state_o), 32'd0);
    check("s6_stop_en_we", {30'd0, cif.en, cif.we}, 32'd0);
    check("s6_stop_status", {29'd0, cif.armed, cif.triggered, cif.cap_done}, 32'd0);

    // S7: asynchronous reset mid-PRE
    drive_cfg(2'b01, 2'd0, 1'b1, 9'h100, 4'd0);
    tick(1);
    tick(10);
    check("s7_pre", 32'(state_o), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("s7_rst_state", 32'(state_o), 32'd0);
    check("s7_rst_addr", 32'(cif.addr), 32'd0);
    check("s7_rst_en_we", {30'd0, cif.en, cif.we}, 32'd0);
    check("s7_rst_status", {29'd0, cif.armed, cif.triggered, cif.cap_done}, 32'd0);
    check("s7_rst_trace_end", 32'(cif.trace_end), 32'd0);
    cif.trig_mode = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
